boton_pulsos: RTL and testbench

//  Upstream stage of the up/down counter: turns two raw push-buttons into clean

---
 rtl/boton_pulsos.sv | 128 ++++++++++++
 tb/tb_boton_pulsos.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boton_pulsos.sv
// Two raw push-buttons to clean single-cycle count requests: 2-FF sync, debounce
// filter and per-button press FSM with optional auto-repeat. Index 1 = up, 0 = down.
//   state  | meaning
//   IDLE   | released, waiting for the debounced level to rise
//   HOLD   | pressed, first pulse issued, timing the auto-repeat delay
//   REPEAT | auto-repeating, one pulse every REPEAT_CYCLES
module boton_pulsos #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] sb,
  output logic [1:0] btn_level
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] stable_q, stable_d;
  logic [1:0] sb_q, sb_d;
  logic [1:0] raw;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0][CW-1:0] tmr_q, tmr_d;
  state_t state_q [2];
  state_t state_d [2];

  always_comb begin
    s1_d     = {btn_up, btn_down};
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    tmr_d    = tmr_q;
    raw      = 2'b00;
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];

    for (int b = 0; b < 2; b++) begin
      if (s2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == DB_LAST) begin
          stable_d[b] = s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end

      // Release wins over any timer expiry, so no pulse is ever issued on release.
      case (state_q[b])
        IDLE: begin
          if (stable_q[b]) begin
            raw[b]     = 1'b1;
            tmr_d[b]   = '0;
            state_d[b] = HOLD;
          end
        end
        HOLD: begin
          if (!stable_q[b]) begin
            state_d[b] = IDLE;
          end else if (REPEAT_EN) begin
            if (tmr_q[b] == HOLD_LAST) begin
              raw[b]     = 1'b1;
              tmr_d[b]   = '0;
              state_d[b] = REPEAT;
            end else begin
              tmr_d[b] = tmr_q[b] + CW'(1);
            end
          end
        end
        REPEAT: begin
          if (!stable_q[b]) begin
            state_d[b] = IDLE;
          end else if (tmr_q[b] == REP_LAST) begin
            raw[b]   = 1'b1;
            tmr_d[b] = '0;
          end else begin
            tmr_d[b] = tmr_q[b] + CW'(1);
          end
        end
        default: state_d[b] = IDLE;
      endcase
    end

    sb_d = (raw == 2'b11) ? 2'b00 : raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= 2'b00;
      s2_q       <= 2'b00;
      stable_q   <= 2'b00;
      sb_q       <= 2'b00;
      cnt_q      <= '0;
      tmr_q      <= '0;
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      stable_q   <= stable_d;
      sb_q       <= sb_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
    end
  end

  assign sb        = sb_q;
  assign btn_level = stable_q;

endmodule

// File: tb/tb_boton_pulsos.sv
// Bench for boton_pulsos: one instance without and one with auto-repeat, both
// checked every cycle against an age-based reference model plus directed checks.
module tb_boton_pulsos;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [1:0] sb0, lvl0, sb1, lvl1;

  int n_pass = 0;
  int n_total = 0;

  boton_pulsos #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .sb(sb0), .btn_level(lvl0));

  boton_pulsos #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .sb(sb1), .btn_level(lvl1));

  always #5 clk = ~clk;

  // Reference model: pulses are a function of how long the debounced level has been high.
  bit [1:0]       s1m, s2m, stm, sbm0, sbm1;
  int             age [2];
  int             since [2];
  logic [D-1:0]   hist [2];

  function automatic bit pulse_at(int a, bit rep);
    return (a == 0) || (rep && a >= H && ((a - H) % R) == 0);
  endfunction

  function automatic void model_reset();
    s1m = 0; s2m = 0; stm = 0; sbm0 = 0; sbm1 = 0;
    for (int b = 0; b < 2; b++) begin
      age[b] = 0; since[b] = 0; hist[b] = '0;
    end
  endfunction

  function automatic void model_step();
    bit [1:0] r0, r1;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 2; b++) begin
      r0[b] = stm[b] && pulse_at(age[b], 1'b0);
      r1[b] = stm[b] && pulse_at(age[b], 1'b1);
    end
    sbm0 = (r0 == 2'b11) ? 2'b00 : r0;
    sbm1 = (r1 == 2'b11) ? 2'b00 : r1;
    for (int b = 0; b < 2; b++) begin
      age[b] = stm[b] ? age[b] + 1 : 0;
      hist[b] = {hist[b][D-2:0], s2m[b]};
      since[b]++;
      if (since[b] >= D && hist[b] == {D{~stm[b]}}) begin
        stm[b] = ~stm[b];
        since[b] = 0;
      end
    end
    s2m = s1m;
    s1m = {btn_up, btn_down};
  endfunction

  task automatic tick(input bit up, input bit dn);
    btn_up = up;
    btn_down = dn;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({sb0, lvl0, sb1, lvl1} !== 8'h00)
      $display("FAIL reset_async: got %b want 00000000", {sb0, lvl0, sb1, lvl1});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== 8'h00)
        $display("FAIL reset_hold cyc %0d: got %b want 00000000", i, {sb0, lvl0, sb1, lvl1});
      else n_pass++;
    end
    #3 rst = 1'b1;
  endtask

  task automatic test_single_press();
    int ev[$];
    int last_lvl = -1;
    for (int n = 1; n <= 30; n++) begin
      tick(n <= 10, 0);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL single cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
      if (sb0[1]) ev.push_back(n);
      if (lvl0[1]) last_lvl = n;
    end
    n_total++;
    if (ev.size() != 1 || ev[0] != 7)
      $display("FAIL single_latency: got %0d pulses first %0d want 1 at 7", ev.size(), ev.size() ? ev[0] : -1);
    else n_pass++;
    n_total++;
    if (last_lvl != 15)
      $display("FAIL single_level_fall: last high edge %0d want 15", last_lvl);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int cnt_bounce = 0;
    int cnt_final = 0;
    for (int n = 0; n < 15; n++) begin
      tick(0, (n % 3) == 0);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL glitch cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
      if (sb0[0] || lvl0[0]) cnt_bounce++;
    end
    n_total++;
    if (cnt_bounce != 0)
      $display("FAIL glitch_only: got %0d active cycles want 0", cnt_bounce);
    else n_pass++;
    for (int n = 0; n < 32; n++) begin
      tick(0, n < 12);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL glitch_stable cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
      if (sb0 == 2'b01) cnt_final++;
    end
    n_total++;
    if (cnt_final != 1)
      $display("FAIL glitch_then_press: got %0d pulses want 1", cnt_final);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int ev[$];
    int exp_ev[6] = '{7, 27, 35, 43, 51, 59};
    int cnt0 = 0;
    for (int n = 1; n <= 85; n++) begin
      tick(n <= 60, 0);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL repeat cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
      if (sb1[1]) ev.push_back(n);
      if (sb0[1]) cnt0++;
    end
    n_total++;
    if (ev.size() != 6)
      $display("FAIL repeat_count: got %0d want 6", ev.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < ev.size(); i++) begin
      n_total++;
      if (ev[i] != exp_ev[i])
        $display("FAIL repeat_edge %0d: got %0d want %0d", i, ev[i], exp_ev[i]);
      else n_pass++;
    end
    n_total++;
    if (cnt0 != 1)
      $display("FAIL norepeat_count: got %0d want 1", cnt0);
    else n_pass++;
  endtask

  task automatic test_conflict();
    int busy = 0;
    int up_e = -1;
    int dn_e = -1;
    for (int n = 1; n <= 30; n++) begin
      tick(n <= 10, n <= 10);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL conflict cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
      if (sb0 != 2'b00) busy++;
      if (n == 8) begin
        n_total++;
        if (lvl0 !== 2'b11) $display("FAIL conflict_level: got %b want 11", lvl0);
        else n_pass++;
      end
    end
    n_total++;
    if (busy != 0) $display("FAIL conflict_drop: got %0d pulses want 0", busy);
    else n_pass++;
    for (int n = 1; n <= 35; n++) begin
      tick(n <= 12, n >= 3 && n <= 14);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL stagger cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
      if (sb0 == 2'b10 && up_e < 0) up_e = n;
      if (sb0 == 2'b01 && dn_e < 0) dn_e = n;
    end
    n_total++;
    if (up_e != 7 || dn_e != 9)
      $display("FAIL stagger_edges: got up %0d down %0d want 7 and 9", up_e, dn_e);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int ev[$];
    for (int n = 1; n <= 40; n++) begin
      tick(1, 0);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL prereset cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
    end
    #3 rst = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({sb0, lvl0, sb1, lvl1} !== 8'h00)
      $display("FAIL midrepeat_reset: got %b want 00000000", {sb0, lvl0, sb1, lvl1});
    else n_pass++;
    for (int n = 0; n < 3; n++) tick(1, 0);
    #3 rst = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick(1, 0);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL postreset cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
      if (sb0[1]) ev.push_back(n);
    end
    n_total++;
    if (ev.size() != 1 || ev[0] != 7)
      $display("FAIL postreset_press: got %0d pulses first %0d want 1 at 7", ev.size(), ev.size() ? ev[0] : -1);
    else n_pass++;
    for (int n = 0; n < 15; n++) tick(0, 0);
  endtask

  task automatic test_random();
    bit up = 0, dn = 0;
    int up_left = 1, dn_left = 1;
    for (int n = 0; n < 420; n++) begin
      if (--up_left == 0) begin up = ~up; up_left = $urandom_range(1, 30); end
      if (--dn_left == 0) begin dn = ~dn; dn_left = $urandom_range(1, 30); end
      if (n >= 400) begin up = 0; dn = 0; end
      tick(up, dn);
      n_total++;
      if ({sb0, lvl0, sb1, lvl1} !== {sbm0, stm, sbm1, stm})
        $display("FAIL random cyc %0d: got %b want %b", n, {sb0, lvl0, sb1, lvl1}, {sbm0, stm, sbm1, stm});
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_glitch();
    test_repeat();
    test_conflict();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal;
  end

endmodule
